// File: rtl/psg_register_file.sv
// SN76489-style host register file: latch/data byte decoder, tone/attenuator/noise registers,
// shared tone prescaler and READY busy-window model.
module psg_register_file #(
    parameter int unsigned Prescale   = 16,
    parameter int unsigned BusyCycles = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    output logic       ready_o,
    output logic       overrun_o,
    output logic       tone_tick_o,
    output logic [9:0] tone0_compare_o,
    output logic [9:0] tone1_compare_o,
    output logic [9:0] tone2_compare_o,
    output logic [3:0] atten0_o,
    output logic [3:0] atten1_o,
    output logic [3:0] atten2_o,
    output logic [3:0] atten3_o,
    output logic [2:0] noise_ctrl_o,
    output logic       noise_reset_o
);

    localparam int unsigned PsW   = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam int unsigned BusyW = $clog2(BusyCycles + 1);
    localparam logic [PsW-1:0]   PsMax    = PsW'(Prescale - 1);
    localparam logic [BusyW-1:0] BusyLoad = BusyW'(BusyCycles);

    logic [PsW-1:0]   ps_q, ps_d;
    logic [BusyW-1:0] busy_q, busy_d;
    logic [2:0]       latched_q, latched_d;
    logic [9:0]       tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
    logic [3:0][3:0]  atten_q, atten_d;
    logic [2:0]       noise_q, noise_d;
    logic             overrun_q, overrun_d;
    logic             nrst_q, nrst_d;

    logic       accept;
    logic       is_latch;
    logic [2:0] tgt;

    // Latch bytes load the low nibble, data bytes the upper six bits.
    function automatic logic [9:0] tone_upd(input logic [9:0] old, input logic latch,
                                            input logic [7:0] d);
        return latch ? {old[9:4], d[3:0]} : {d[5:0], old[3:0]};
    endfunction

    assign ready_o  = (busy_q == '0);
    assign accept   = wr_en_i && ready_o;
    assign is_latch = wr_data_i[7];
    assign tgt      = is_latch ? wr_data_i[6:4] : latched_q;

    always_comb begin
        ps_d      = (ps_q == PsMax) ? '0 : ps_q + PsW'(1);
        busy_d    = (busy_q == '0) ? busy_q : busy_q - BusyW'(1);
        overrun_d = wr_en_i && !ready_o;
        nrst_d    = 1'b0;
        latched_d = latched_q;
        tone0_d   = tone0_q;
        tone1_d   = tone1_q;
        tone2_d   = tone2_q;
        atten_d   = atten_q;
        noise_d   = noise_q;
        if (accept) begin
            busy_d    = BusyLoad;
            latched_d = tgt;
            if (tgt[0]) begin
                atten_d[tgt[2:1]] = wr_data_i[3:0];
            end else begin
                unique case (tgt[2:1])
                    2'd0: tone0_d = tone_upd(tone0_q, is_latch, wr_data_i);
                    2'd1: tone1_d = tone_upd(tone1_q, is_latch, wr_data_i);
                    2'd2: tone2_d = tone_upd(tone2_q, is_latch, wr_data_i);
                    2'd3: begin
                        noise_d = wr_data_i[2:0];
                        nrst_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q      <= '0;
            busy_q    <= '0;
            latched_q <= 3'b000;
            tone0_q   <= '0;
            tone1_q   <= '0;
            tone2_q   <= '0;
            atten_q   <= {4{4'hF}};
            noise_q   <= '0;
            overrun_q <= 1'b0;
            nrst_q    <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            busy_q    <= busy_d;
            latched_q <= latched_d;
            tone0_q   <= tone0_d;
            tone1_q   <= tone1_d;
            tone2_q   <= tone2_d;
            atten_q   <= atten_d;
            noise_q   <= noise_d;
            overrun_q <= overrun_d;
            nrst_q    <= nrst_d;
        end
    end

    assign tone_tick_o     = (ps_q == PsMax);
    assign overrun_o       = overrun_q;
    assign noise_reset_o   = nrst_q;
    assign tone0_compare_o = tone0_q;
    assign tone1_compare_o = tone1_q;
    assign tone2_compare_o = tone2_q;
    assign atten0_o        = atten_q[0];
    assign atten1_o        = atten_q[1];
    assign atten2_o        = atten_q[2];
    assign atten3_o        = atten_q[3];
    assign noise_ctrl_o    = noise_q;

endmodule

// File: tb/tb_psg_register_file.sv
// Randomized + directed bench for psg_register_file against a cycle-count based reference model.
module tb_psg_register_file;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready, overrun, tone_tick, noise_reset;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic [2:0] noise_ctrl;

    int n_vec = 0;
    int n_err = 0;

    psg_register_file dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .ready_o        (ready),
        .overrun_o      (overrun),
        .tone_tick_o    (tone_tick),
        .tone0_compare_o(tone0),
        .tone1_compare_o(tone1),
        .tone2_compare_o(tone2),
        .atten0_o       (atten0),
        .atten1_o       (atten1),
        .atten2_o       (atten2),
        .atten3_o       (atten3),
        .noise_ctrl_o   (noise_ctrl),
        .noise_reset_o  (noise_reset)
    );

    always #5 clk = ~clk;

    // Reference model: time measured in clock edges since reset release.
    int m_cyc, m_busy_until, m_latched, m_noise;
    int m_tone[3];
    int m_atten[4];
    bit m_ovr, m_nrst;

    function automatic bit m_ready();
        return m_cyc >= m_busy_until;
    endfunction

    task automatic m_init();
        m_cyc = 0; m_busy_until = 0; m_latched = 0; m_noise = 0;
        m_ovr = 0; m_nrst = 0;
        for (int i = 0; i < 3; i++) m_tone[i] = 0;
        for (int i = 0; i < 4; i++) m_atten[i] = 15;
    endtask

    task automatic m_write(input int b);
        int ch, typ;
        if (b >= 128) m_latched = (b >> 4) & 7;
        ch  = m_latched >> 1;
        typ = m_latched & 1;
        if (typ == 1) m_atten[ch] = b % 16;
        else if (ch == 3) begin
            m_noise = b % 8;
            m_nrst  = 1;
        end else if (b >= 128) m_tone[ch] = (m_tone[ch] / 16) * 16 + b % 16;
        else m_tone[ch] = (b % 64) * 16 + m_tone[ch] % 16;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_init();
        else begin
            bit rdy;
            rdy    = m_ready();
            m_cyc  = m_cyc + 1;
            m_ovr  = wr_en && !rdy;
            m_nrst = 0;
            if (wr_en && rdy) begin
                m_write(int'(wr_data));
                m_busy_until = m_cyc + 32;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(m_ready()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("tone_tick", 32'(tone_tick), 32'((m_cyc % 16) == 15));
        chk("tone0", 32'(tone0), 32'(m_tone[0]));
        chk("tone1", 32'(tone1), 32'(m_tone[1]));
        chk("tone2", 32'(tone2), 32'(m_tone[2]));
        chk("atten0", 32'(atten0), 32'(m_atten[0]));
        chk("atten1", 32'(atten1), 32'(m_atten[1]));
        chk("atten2", 32'(atten2), 32'(m_atten[2]));
        chk("atten3", 32'(atten3), 32'(m_atten[3]));
        chk("noise_ctrl", 32'(noise_ctrl), 32'(m_noise));
        chk("noise_reset", 32'(noise_reset), 32'(m_nrst));
    end

    // Inputs change 2 time units after each rising edge.
    task automatic step(input logic en, input logic [7:0] d);
        @(posedge clk);
        #2;
        wr_en   = en;
        wr_data = d;
    endtask

    // Counts further low-ready cycles until ready returns, bounded.
    task automatic wait_ready(input string name, inout int low);
        int guard = 0;
        forever begin
            step(1'b0, 8'h00);
            if (ready) break;
            low++;
            guard++;
            if (guard > 100) begin
                chk({name, "_timeout"}, 32'(guard), 32'd0);
                break;
            end
        end
    endtask

    task automatic write_byte(input string name, input logic [7:0] b);
        int low = 0;
        step(1'b1, b);
        wait_ready(name, low);
        chk({name, "_busy_len"}, 32'(low), 32'd32);
    endtask

    initial begin
        int low;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_atten3", 32'(atten3), 32'hF);
        chk("rst_tone1", 32'(tone1), 32'h000);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 8'h00);
            if (i == 14) chk("tick_early", 32'(tone_tick), 32'd0);
        end
        chk("tick_first", 32'(tone_tick), 32'd1);

        write_byte("w8E", 8'h8E);
        write_byte("w0F", 8'h0F);
        chk("tone0_0FE", 32'(tone0), 32'h0FE);
        chk("tone1_keep", 32'(tone1), 32'h000);

        write_byte("w9A", 8'h9A);
        chk("atten0_A", 32'(atten0), 32'hA);
        write_byte("w03", 8'h03);
        chk("atten0_3", 32'(atten0), 32'h3);

        step(1'b1, 8'hE5);
        step(1'b0, 8'h00);
        chk("noise_pulse1", 32'(noise_reset), 32'd1);
        chk("noise_5", 32'(noise_ctrl), 32'd5);
        low = 1;
        wait_ready("wE5", low);
        step(1'b1, 8'h02);
        step(1'b0, 8'h00);
        chk("noise_pulse2", 32'(noise_reset), 32'd1);
        step(1'b0, 8'h00);
        chk("noise_pulse_end", 32'(noise_reset), 32'd0);
        chk("noise_2", 32'(noise_ctrl), 32'd2);
        low = 2;
        wait_ready("w02", low);

        step(1'b1, 8'hC1);
        step(1'b1, 8'h3F);
        step(1'b0, 8'h00);
        chk("overrun_pulse", 32'(overrun), 32'd1);
        low = 2;
        wait_ready("wC1", low);
        chk("busy_not_extended", 32'(low), 32'd32);
        chk("tone2_001", 32'(tone2), 32'h001);

        step(1'b1, 8'h8E);
        repeat (5) step(1'b0, 8'h00);
        rst = 1'b1;
        #1;
        chk("midbusy_ready", 32'(ready), 32'd1);
        chk("midbusy_tone0", 32'(tone0), 32'h000);
        step(1'b0, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) step(1'b0, 8'h00);
        chk("tick_restart", 32'(tone_tick), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            logic en;
            en = m_ready() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            step(en, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                step(1'b0, 8'h00);
                rst = 1'b0;
            end
        end
        step(1'b0, 8'h00);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
